instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage: holds the architectural PC register, fetches from instruction memory via req/ack
//  and presents {Instruction, CurrentPC} to decode via valid/ready.
//  CurrentPC feeds the next-PC adder/branch mux downstream.
//  The mux's NextPC result is loaded back into the PC when decode accepts the instruction.
//  Also handles redirects, misalignment and memory-timeout faults.
// PARAMETERS
//  PC_WIDTH     64     width of PC, NextPC, RedirectPC, IMemAddr
//  INSTR_WIDTH  32     instruction word width
//  RESET_PC     64'h0  PC value loaded on reset
//  TIMEOUT      255    max cycles waiting for IMemAck before fault (1..65535)
// PORTS
//  CLK          in   1            clock; all state updates on rising edge
//  Reset_L      in   1            asynchronous, active-low reset
//  NextPC       in   PC_WIDTH     next PC from branch/next-PC logic, sampled on accept
//  Redirect     in   1            force PC to RedirectPC (flush)
//  RedirectPC   in   PC_WIDTH     redirect target
//  IMemReq      out  1            fetch request to instruction memory
//  IMemAddr     out  PC_WIDTH     fetch address (== CurrentPC)
//  IMemAck      in   1            memory data valid this cycle
//  IMemData     in   INSTR_WIDTH  fetched instruction word
//  InstrValid   out  1            Instruction/CurrentPC valid to decode
//  InstrReady   in   1            decode accepts this cycle
//  Instruction  out  INSTR_WIDTH  registered fetched word
//  CurrentPC    out  PC_WIDTH     PC of Instruction / address being fetched
//  Fault        out  1            sticky fault flag
//  FaultCode    out  2            2'b01 misaligned PC, 2'b10 IMem timeout, 2'b00 none
//  FetchCount   out  32           retired-fetch counter, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (Reset_L=0, async)
//   - state=IDLE, CurrentPC=RESET_PC, IMemReq=0, InstrValid=0, Instruction=0
//   - Fault=0, FaultCode=0, FetchCount=0, wait counter=0
//  States: IDLE, FETCH, DELIVER, FAULT. Outputs are Moore, from registered state.
//  IDLE -> FETCH unconditionally on the next edge (one bubble after reset release).
//  FETCH
//   - IMemReq=1, IMemAddr=CurrentPC. Memory responds to the address currently presented (stateless).
//   - On IMemAck: Instruction<=IMemData, go to DELIVER, wait counter cleared.
//     Ack in cycle N -> InstrValid=1 in N+1.
//   - No ack: wait counter++. On the cycle the counter reaches TIMEOUT: FAULT, FaultCode=2'b10.
//  DELIVER
//   - InstrValid=1; Instruction and CurrentPC held stable until accepted.
//   - On InstrValid&InstrReady:
//     - CurrentPC<=NextPC, FetchCount++.
//     - If NextPC[1:0]!=0: FAULT, FaultCode=2'b01. Else FETCH (IMemReq=1 at new address in M+1).
//  Redirect (IDLE/FETCH/DELIVER)
//   - Highest priority below reset.
//   - CurrentPC<=RedirectPC, state<=FETCH, InstrValid<=0, wait counter cleared.
//   - Same-cycle IMemAck and InstrReady are ignored; FetchCount is not incremented.
//   - RedirectPC[1:0]!=0 -> FAULT, code 2'b01.
//  FAULT
//   - Sticky until Reset_L: IMemReq=0, InstrValid=0, Redirect ignored.
//   - CurrentPC holds the offending value.
//  Widths: PC arithmetic is not done here; NextPC is used as-is. FetchCount wraps modulo 2^32.
//  Throughput: zero-wait memory -> one instruction per 2 cycles with InstrReady held high.
// STRUCTURE
//  Shared package fetch_pkg:
//   - state encoding (IDLE=2'd0, FETCH=2'd1, DELIVER=2'd2, FAULT=2'd3)
//   - FaultCode constants: FC_NONE, FC_MISALIGN, FC_TIMEOUT
//   - shared with decode/hazard logic and the bench
//  Sub-module fetch_watchdog: clear/enable wait counter sized $clog2(TIMEOUT+1), expired output.
//  All other logic (FSM, PC register, output regs, FetchCount) lives in instr_fetch_stage.
// TESTING
//  1. Reset, RESET_PC=0, IMem zero-wait, InstrReady=1, NextPC=CurrentPC+4
//     -> IMemAddr 0,4,8 on alternating cycles; FetchCount=3 after 3 accepts.
//  2. Hold InstrReady=0 for 5 cycles in DELIVER
//     -> InstrValid stays 1; Instruction and CurrentPC stable; PC does not advance; then accept.
//  3. In DELIVER assert Redirect, RedirectPC=64'h100, same-cycle InstrReady=1
//     -> next IMemAddr=0x100; FetchCount unchanged; InstrValid=0 for one cycle.
//  4. Accept with NextPC=64'h102
//     -> Fault=1, FaultCode=2'b01, CurrentPC=0x102; IMemReq stays 0 even with later Redirect.
//  5. TIMEOUT=8, never assert IMemAck
//     -> Fault=1, FaultCode=2'b10, exactly 8 cycles after FETCH entry.
//  6. Drop Reset_L mid-DELIVER between clock edges
//     -> outputs return to reset values immediately; IDLE then FETCH at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and fault codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFetch   = 2'd1,
        StDeliver = 2'd2,
        StFault   = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    // Instructions are word aligned; any set low bit is a fault.
    function automatic logic misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter for outstanding fetches; expired_o flags the cycle on
// which the count would reach Timeout.
module fetch_watchdog #(
    parameter int unsigned Timeout = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic [CntW-1:0] cnt_q;

    // Count waiting cycles; clear has priority over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Fires when this enabled cycle takes the count to Timeout.
    always_comb begin
        expired_o = en_i && (cnt_q == CntW'(Timeout - 1));
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, req/ack instruction memory fetch, valid/ready
// hand-off to decode, redirect handling and sticky fault reporting.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned          TIMEOUT     = 255
) (
    input  logic                   CLK,
    input  logic                   Reset_L,
    input  logic [PC_WIDTH-1:0]    NextPC,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    RedirectPC,
    output logic                   IMemReq,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    input  logic                   IMemAck,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    output logic                   InstrValid,
    input  logic                   InstrReady,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [PC_WIDTH-1:0]    CurrentPC,
    output logic                   Fault,
    output logic [1:0]             FaultCode,
    output logic [31:0]            FetchCount
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [1:0]             fcode_q, fcode_d;
    logic [31:0]            fcount_q, fcount_d;

    logic redirect_act;
    logic wd_clear;
    logic wd_en;
    logic wd_expired;

    // Redirect is ignored once faulted.
    always_comb begin
        redirect_act = Redirect && (state_q != StFault);
        wd_clear     = redirect_act || ((state_q == StFetch) && IMemAck);
        wd_en        = !redirect_act && (state_q == StFetch) && !IMemAck;
    end

    fetch_watchdog #(
        .Timeout(TIMEOUT)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_ni   (Reset_L),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            fcode_q  <= FC_NONE;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            fcode_q  <= fcode_d;
            fcount_q <= fcount_d;
        end
    end

    // Next-state: redirect first, then per-state fetch/deliver progress.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        fcode_d  = fcode_q;
        fcount_d = fcount_q;
        if (redirect_act) begin
            pc_d = RedirectPC;
            if (misaligned(RedirectPC[1:0])) begin
                state_d = StFault;
                fcode_d = FC_MISALIGN;
            end else begin
                state_d = StFetch;
            end
        end else begin
            case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (IMemAck) begin
                        instr_d = IMemData;
                        state_d = StDeliver;
                    end else if (wd_expired) begin
                        state_d = StFault;
                        fcode_d = FC_TIMEOUT;
                    end
                end
                StDeliver: begin
                    if (InstrReady) begin
                        pc_d     = NextPC;
                        fcount_d = fcount_q + 32'd1;
                        if (misaligned(NextPC[1:0])) begin
                            state_d = StFault;
                            fcode_d = FC_MISALIGN;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs from registered state.
    always_comb begin
        IMemReq     = (state_q == StFetch);
        IMemAddr    = pc_q;
        InstrValid  = (state_q == StDeliver);
        Instruction = instr_q;
        CurrentPC   = pc_q;
        Fault       = (state_q == StFault);
        FaultCode   = fcode_q;
        FetchCount  = fcount_q;
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, hand-written timeout and
// async-reset sequences, then randomized traffic against a behavioural model.
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] NextPC;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [63:0] CurrentPC;
    logic        Fault;
    logic [1:0]  FaultCode;
    logic [31:0] FetchCount;

    always #5 CLK = ~CLK;

    instr_fetch_stage #(
        .PC_WIDTH   (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'h0),
        .TIMEOUT    (TO)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .NextPC     (NextPC),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instruction(Instruction),
        .CurrentPC  (CurrentPC),
        .Fault      (Fault),
        .FaultCode  (FaultCode),
        .FetchCount (FetchCount)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory image: a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_5A5A;
    endfunction

    // Behavioural model: what the fetch stage is doing, as flags and counters.
    bit          m_idle, m_req, m_valid, m_fault;
    logic [1:0]  m_code;
    logic [63:0] m_pc;
    logic [31:0] m_instr, m_cnt;
    int          m_wait;

    task automatic model_reset();
        m_idle = 1; m_req = 0; m_valid = 0; m_fault = 0; m_code = FC_NONE;
        m_pc = 64'h0; m_instr = 32'h0; m_cnt = 32'h0; m_wait = 0;
    endtask

    task automatic model_step();
        if (m_fault) begin
        end else if (Redirect) begin
            m_pc = RedirectPC; m_wait = 0; m_valid = 0; m_idle = 0;
            if (RedirectPC[1:0] != 2'b00) begin
                m_fault = 1; m_code = FC_MISALIGN; m_req = 0;
            end else begin
                m_req = 1;
            end
        end else if (m_idle) begin
            m_idle = 0; m_req = 1;
        end else if (m_req) begin
            if (IMemAck) begin
                m_instr = IMemData; m_req = 0; m_valid = 1; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == int'(TO)) begin
                    m_fault = 1; m_code = FC_TIMEOUT; m_req = 0;
                end
            end
        end else if (m_valid && InstrReady) begin
            m_pc = NextPC; m_cnt = m_cnt + 32'd1; m_valid = 0;
            if (NextPC[1:0] != 2'b00) begin
                m_fault = 1; m_code = FC_MISALIGN;
            end else begin
                m_req = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"},   64'(IMemReq),     64'(m_req));
        chk({tag, ".addr"},  IMemAddr,         m_pc);
        chk({tag, ".valid"}, 64'(InstrValid),  64'(m_valid));
        chk({tag, ".pc"},    CurrentPC,        m_pc);
        chk({tag, ".instr"}, 64'(Instruction), 64'(m_instr));
        chk({tag, ".fault"}, 64'(Fault),       64'(m_fault));
        chk({tag, ".code"},  64'(FaultCode),   64'(m_code));
        chk({tag, ".cnt"},   64'(FetchCount),  64'(m_cnt));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle(input string tag);
        model_step();
        tick();
        IMemData = mem(m_pc);
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        Redirect = 0; IMemAck = 0; InstrReady = 0; NextPC = 64'h0; RedirectPC = 64'h0;
        Reset_L = 0;
        #1;
        model_reset();
        check_model(tag);
        @(posedge CLK);
        #2;
        Reset_L = 1;
        IMemData = mem(64'h0);
        #1;
    endtask

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        ack;
        logic        rdy;
        logic [63:0] npc;
        logic        e_req;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_fault;
        logic [1:0]  e_code;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic redir, logic [63:0] rpc, logic ack, logic rdy,
                                logic [63:0] npc, logic e_req, logic e_valid,
                                logic [63:0] e_pc, logic e_fault, logic [1:0] e_code,
                                logic [31:0] e_cnt);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdy = rdy; v.npc = npc;
        v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_fault = e_fault;
        v.e_code = e_code; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed vectors: streaming, stall, redirect, misaligned accept.
        tbl.push_back(mk(0, 0, 0, 1, 0,      1, 0, 64'h0,   0, FC_NONE, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,      0, 1, 64'h0,   0, FC_NONE, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h4,  1, 0, 64'h4,   0, FC_NONE, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0,      0, 1, 64'h4,   0, FC_NONE, 1));
        tbl.push_back(mk(0, 0, 0, 1, 64'h8,  1, 0, 64'h8,   0, FC_NONE, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0,      0, 1, 64'h8,   0, FC_NONE, 2));
        tbl.push_back(mk(0, 0, 0, 1, 64'hC,  1, 0, 64'hC,   0, FC_NONE, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0,      0, 1, 64'hC,   0, FC_NONE, 3));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 1, 0, 64'h40, 0, 1, 64'hC, 0, FC_NONE, 3));
        tbl.push_back(mk(0, 0, 0, 1, 64'h10, 1, 0, 64'h10,  0, FC_NONE, 4));
        tbl.push_back(mk(0, 0, 1, 1, 0,      0, 1, 64'h10,  0, FC_NONE, 4));
        tbl.push_back(mk(1, 64'h100, 0, 1, 64'h14, 1, 0, 64'h100, 0, FC_NONE, 4));
        tbl.push_back(mk(1, 64'h180, 1, 1, 0,      1, 0, 64'h180, 0, FC_NONE, 4));
        tbl.push_back(mk(0, 0, 1, 1, 0,      0, 1, 64'h180, 0, FC_NONE, 4));
        tbl.push_back(mk(0, 0, 0, 1, 64'h102, 0, 0, 64'h102, 1, FC_MISALIGN, 5));
        tbl.push_back(mk(1, 64'h200, 1, 1, 0, 0, 0, 64'h102, 1, FC_MISALIGN, 5));
        tbl.push_back(mk(1, 64'h300, 0, 0, 0, 0, 0, 64'h102, 1, FC_MISALIGN, 5));

        do_reset("reset");
        chk("post_release_idle_req", 64'(IMemReq), 64'h0);

        foreach (tbl[i]) begin
            Redirect = tbl[i].redir; RedirectPC = tbl[i].rpc; IMemAck = tbl[i].ack;
            InstrReady = tbl[i].rdy; NextPC = tbl[i].npc;
            tick();
            chk($sformatf("vec%0d.req", i),   64'(IMemReq),    64'(tbl[i].e_req));
            chk($sformatf("vec%0d.valid", i), 64'(InstrValid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d.pc", i),    CurrentPC,       tbl[i].e_pc);
            chk($sformatf("vec%0d.addr", i),  IMemAddr,        tbl[i].e_pc);
            chk($sformatf("vec%0d.fault", i), 64'(Fault),      64'(tbl[i].e_fault));
            chk($sformatf("vec%0d.code", i),  64'(FaultCode),  64'(tbl[i].e_code));
            chk($sformatf("vec%0d.cnt", i),   64'(FetchCount), 64'(tbl[i].e_cnt));
            if (tbl[i].e_valid)
                chk($sformatf("vec%0d.instr", i), 64'(Instruction), 64'(mem(tbl[i].e_pc)));
            IMemData = mem(tbl[i].e_pc);
        end

        // Timeout: no ack ever; fault lands exactly TO edges after FETCH entry.
        do_reset("reset_to");
        tick();
        chk("to.entry_req", 64'(IMemReq), 64'h1);
        for (int k = 1; k < int'(TO); k++) tick();
        chk("to.before_fault", 64'(Fault), 64'h0);
        chk("to.before_req", 64'(IMemReq), 64'h1);
        tick();
        chk("to.fault", 64'(Fault), 64'h1);
        chk("to.code", 64'(FaultCode), 64'(FC_TIMEOUT));
        chk("to.req", 64'(IMemReq), 64'h0);

        // Async reset mid-DELIVER.
        do_reset("reset_ar");
        tick();
        IMemAck = 1; IMemData = mem(64'h0);
        tick();
        IMemAck = 0; InstrReady = 1; NextPC = 64'h4;
        tick();
        InstrReady = 0; IMemAck = 1; IMemData = mem(64'h4);
        tick();
        IMemAck = 0;
        chk("ar.valid_before", 64'(InstrValid), 64'h1);
        chk("ar.cnt_before", 64'(FetchCount), 64'h1);
        #2;
        Reset_L = 0;
        #1;
        chk("ar.valid", 64'(InstrValid), 64'h0);
        chk("ar.req", 64'(IMemReq), 64'h0);
        chk("ar.pc", CurrentPC, 64'h0);
        chk("ar.instr", 64'(Instruction), 64'h0);
        chk("ar.cnt", 64'(FetchCount), 64'h0);
        @(posedge CLK);
        #2;
        Reset_L = 1;
        #1;
        chk("ar.idle_req", 64'(IMemReq), 64'h0);
        tick();
        chk("ar.fetch_req", 64'(IMemReq), 64'h1);
        chk("ar.fetch_addr", IMemAddr, 64'h0);

        // Randomized traffic against the model.
        do_reset("reset_rnd");
        for (int c = 0; c < 800; c++) begin
            logic [63:0] rpc;
            if (m_fault && $urandom_range(3) == 0) begin
                do_reset("rnd_reset");
            end else begin
                rpc = {32'h0, $urandom};
                rpc[1:0] = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
                Redirect   = ($urandom_range(15) == 0);
                RedirectPC = rpc;
                IMemAck    = $urandom_range(1) == 1;
                InstrReady = $urandom_range(3) != 0;
                NextPC     = ($urandom_range(31) == 0) ? m_pc + 64'd6 : m_pc + 64'd4;
                cycle($sformatf("rnd%0d", c));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
